fw_dut_port_arbiter: RTL and testbench
======================================

Name: fw_dut_port_arbiter

Overview:
Parametrised successor to the fixed 4-firmware FW-to-DUT pin mux. It routes one of NUM_FW firmware blocks onto the shared DUT pins, with registered (IOB) outputs and synchronised inputs. It adds a guarded ownership-switch state machine that holds idle pin levels for a programmable gap, plus multi-hot select detection. Input fan-back goes only to the active owner. Sits between the per-test firmware blocks and the FPGA pins.

Parameters:
NUM_FW, 4, number of firmware masters (2..15)
NUM_OUT, 9, FPGA-to-DUT pins
NUM_IN, 5, DUT-to-FPGA pins
SYNC_STAGES, 2, input synchroniser depth (1..4)
SWITCH_GAP, 4, idle cycles forced on dut_out during an ownership change (1..255)
OUT_IDLE, '0, NUM_OUT-bit pin level driven when no owner or draining (e.g. reset_not bit = 0)

Ports:
S_AXI_ACLK  in  1  clock; all logic in this domain
S_AXI_ARESET  in  1  asynchronous, active-high reset
fw_dev_id_enable  in  NUM_FW  one-hot owner select, quasi-static, same clock domain
fw_out  in  NUM_FW*NUM_OUT  per-firmware pin drive; slice k = bits [k*NUM_OUT +: NUM_OUT]
fw_in  out  NUM_FW*NUM_IN  per-firmware received DUT pins
dut_out  out  NUM_OUT  registered FPGA pins to DUT
dut_in  in  NUM_IN  DUT pins, asynchronous
active_id  out  $clog2(NUM_FW)  current owner index
active_valid  out  1  high in ACTIVE
switch_busy  out  1  high in DRAIN
sel_error  out  1  sticky: multi-hot select seen
sel_error_clr  in  1  single-cycle clear of sel_error
switch_count  out  16  number of entries into ACTIVE, saturating at 0xFFFF

Behaviour:
- Reset (async assert, sync release) state: IDLE; dut_out=OUT_IDLE; fw_in=0; active_id=0; active_valid=0; switch_busy=0; sel_error=0; switch_count=0; sync flops=0. Asserting mid-operation forces these values immediately.
- Select decode each edge: legal = exactly one bit set; zero = no request; multi-hot = error.
- FSM states:
  - IDLE:
    - legal select -> ACTIVE, owner=index; switch_count+1.
    - zero or multi-hot -> stay.
  - ACTIVE:
    - select equals owner one-hot -> stay.
    - any other value (other one-hot, zero, or multi-hot) -> DRAIN; gap counter loads SWITCH_GAP-1.
  - DRAIN:
    - counter decrements each cycle.
    - At count 0, re-sample the select: legal -> ACTIVE with the new index (which may be the old owner); switch_count+1. Otherwise -> IDLE.
    - Select changes during DRAIN do not restart the counter.
- dut_out register input is taken from the state before the edge:
  - ACTIVE -> fw_out[owner].
  - Otherwise -> OUT_IDLE.
- Output timing:
  - Output latency is 1 cycle.
  - Switch at edge E0: dut_out still carries the old owner at E0, then OUT_IDLE for exactly SWITCH_GAP edges, then the new owner from E0+SWITCH_GAP+1.
  - IDLE->ACTIVE at E0: owner drive appears from E0+1.
- Input path:
  - dut_in passes through SYNC_STAGES flops, then a registered fan-out.
  - fw_in slice k = synchronised value when ACTIVE and owner==k, else 0.
  - Non-owners always read 0.
  - Latency from dut_in change to fw_in is SYNC_STAGES+1 edges.
- sel_error:
  - Set on any edge where the select is multi-hot.
  - Cleared by sel_error_clr.
  - Set wins over a simultaneous clear.
- switch_count saturates at 0xFFFF and never wraps.
- active_id, active_valid and switch_busy are registered and reflect the current state.

Decomposition:
- Package fw_dut_arb_pkg:
  - state enum {ST_IDLE, ST_ACTIVE, ST_DRAIN}
  - function is_onehot(vec)
  - function onehot_to_idx(vec)
  - constant CNT_W=16
- Sub-module bit_sync_chain (WIDTH, STAGES; async active-high reset). Instantiated once for dut_in.

Test Plan:
- Reset, then select=0001 with fw_out[0]=9'h1A5 -> dut_out=9'h1A5 one edge after ACTIVE; active_id=0; switch_count=1.
- While owner 0, set select=0100 with fw_out[2]=9'h0F0 and SWITCH_GAP=4 -> dut_out=OUT_IDLE for exactly 4 edges, then 9'h0F0; switch_busy high for 4 cycles; switch_count=2.
- Set select=0011 while ACTIVE -> DRAIN then IDLE; sel_error=1; pulse sel_error_clr with select back to 0001 -> sel_error=0; ACTIVE owner 0.
- Owner 1 with dut_in toggling 5'h15 -> fw_in slice 1 = 5'h15 after SYNC_STAGES+1 edges; slices 0, 2 and 3 stay 0.
- Assert S_AXI_ARESET mid-DRAIN -> all outputs take reset values immediately; after release, IDLE with no owner until a legal select.
- Perform 65,540 switches (or force the counter near 0xFFFF) -> switch_count holds at 0xFFFF.

Source files
------------

// File: rtl/fw_dut_arb_pkg.sv
// Shared types and helpers for the firmware-to-DUT pin arbiter.
// No logic of its own; pure combinational helper functions.
// No flow control involved.
package fw_dut_arb_pkg;

    // Width of the ownership-change counter.
    localparam int CNT_W   = 16;
    // Widest select vector the helpers accept (NUM_FW is at most 15).
    localparam int SEL_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [SEL_MAX-1:0] vec);
        return (vec != '0) && ((vec & (vec - SEL_MAX'(1))) == '0);
    endfunction

    // Index of the set bit; only meaningful when is_onehot(vec) holds.
    function automatic logic [3:0] onehot_to_idx(input logic [SEL_MAX-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < SEL_MAX; i++) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fw_dut_port_arbiter_bit_sync_chain.sv
// Multi-flop synchroniser for asynchronous DUT input pins.
// Latency: STAGES clock edges.
// No backpressure; samples every edge.
module bit_sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESET,
    input  logic [WIDTH-1:0] async_dat,
    output logic [WIDTH-1:0] sync_dat
);

    logic [WIDTH-1:0] stg_q [STAGES];

    // Shift the asynchronous pins through the flop chain.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
        end else begin
            stg_q[0] <= async_dat;
            for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign sync_dat = stg_q[STAGES-1];

endmodule

// File: rtl/fw_dut_port_arbiter.sv
// Routes one of NUM_FW firmware blocks onto the shared DUT pins with a guarded owner switch.
// Latency: dut_out 1 edge after the state; fw_in SYNC_STAGES+1 edges after dut_in.
// No backpressure; ownership changes force SWITCH_GAP idle cycles on the pins.
module fw_dut_port_arbiter
    import fw_dut_arb_pkg::*;
#(
    parameter int                 NUM_FW      = 4,
    parameter int                 NUM_OUT     = 9,
    parameter int                 NUM_IN      = 5,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 SWITCH_GAP  = 4,
    parameter logic [NUM_OUT-1:0] OUT_IDLE    = '0
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    input  logic [NUM_FW-1:0]           fw_dev_id_enable,
    input  logic [NUM_FW*NUM_OUT-1:0]   fw_out,
    output logic [NUM_FW*NUM_IN-1:0]    fw_in,
    output logic [NUM_OUT-1:0]          dut_out,
    input  logic [NUM_IN-1:0]           dut_in,
    output logic [$clog2(NUM_FW)-1:0]   active_id,
    output logic                        active_valid,
    output logic                        switch_busy,
    output logic                        sel_error,
    input  logic                        sel_error_clr,
    output logic [CNT_W-1:0]            switch_count
);

    localparam int             ID_W     = $clog2(NUM_FW);
    localparam logic [7:0]     GAP_INIT = 8'(SWITCH_GAP - 1);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [7:0]             gap_q, gap_d;
    logic                   enter_active;
    logic [CNT_W-1:0]       switch_count_q;

    logic [SEL_MAX-1:0]     sel_ext;
    logic                   sel_legal;
    logic                   sel_multi;
    logic [ID_W-1:0]        sel_idx;
    logic [NUM_FW-1:0]      owner_oh;

    logic [NUM_IN-1:0]      dut_in_sync;
    logic [NUM_OUT-1:0]     owner_pins;
    logic [NUM_FW*NUM_IN-1:0] fw_in_d;

    // Select decode: legal one-hot, empty, or multi-hot.
    assign sel_ext   = SEL_MAX'(fw_dev_id_enable);
    assign sel_legal = is_onehot(sel_ext);
    assign sel_multi = !sel_legal && (fw_dev_id_enable != '0);
    assign sel_idx   = ID_W'(onehot_to_idx(sel_ext));
    assign owner_oh  = NUM_FW'(1) << owner_q;

    bit_sync_chain #(
        .WIDTH  (NUM_IN),
        .STAGES (SYNC_STAGES)
    ) u_dut_in_sync (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .async_dat    (dut_in),
        .sync_dat     (dut_in_sync)
    );

    // Ownership FSM: any departure from the current owner's one-hot forces a drain gap.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        gap_d        = gap_q;
        enter_active = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_legal) begin
                    state_d      = ST_ACTIVE;
                    owner_d      = sel_idx;
                    enter_active = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (fw_dev_id_enable != owner_oh) begin
                    state_d = ST_DRAIN;
                    gap_d   = GAP_INIT;
                end
            end
            ST_DRAIN: begin
                if (gap_q == '0) begin
                    if (sel_legal) begin
                        state_d      = ST_ACTIVE;
                        owner_d      = sel_idx;
                        enter_active = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Current owner's pin drive, selected by index.
    always_comb begin
        owner_pins = OUT_IDLE;
        for (int k = 0; k < NUM_FW; k++) begin
            if (owner_q == ID_W'(k)) owner_pins = fw_out[k*NUM_OUT +: NUM_OUT];
        end
    end

    // Input fan-back: only the active owner sees the synchronised DUT pins.
    always_comb begin
        fw_in_d = '0;
        for (int k = 0; k < NUM_FW; k++) begin
            if (state_q == ST_ACTIVE && owner_q == ID_W'(k)) begin
                fw_in_d[k*NUM_IN +: NUM_IN] = dut_in_sync;
            end
        end
    end

    // State, owner, gap counter and status flags.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            gap_q        <= '0;
            active_valid <= 1'b0;
            switch_busy  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            gap_q        <= gap_d;
            active_valid <= (state_d == ST_ACTIVE);
            switch_busy  <= (state_d == ST_DRAIN);
        end
    end

    // IOB pin registers: drive taken from the pre-edge state.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            dut_out <= OUT_IDLE;
            fw_in   <= '0;
        end else begin
            dut_out <= (state_q == ST_ACTIVE) ? owner_pins : OUT_IDLE;
            fw_in   <= fw_in_d;
        end
    end

    // Sticky multi-hot flag; a new error beats a same-cycle clear.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            sel_error <= 1'b0;
        end else if (sel_multi) begin
            sel_error <= 1'b1;
        end else if (sel_error_clr) begin
            sel_error <= 1'b0;
        end
    end

    // Saturating count of entries into ACTIVE.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            switch_count_q <= '0;
        end else if (enter_active && switch_count_q != {CNT_W{1'b1}}) begin
            switch_count_q <= switch_count_q + CNT_W'(1);
        end
    end

    assign active_id    = owner_q;
    assign switch_count = switch_count_q;

endmodule

// File: tb/tb_fw_dut_port_arbiter.sv
module tb_fw_dut_port_arbiter;
    import fw_dut_arb_pkg::*;

    localparam int NUM_FW = 4;
    localparam int NUM_OUT = 9;
    localparam int NUM_IN = 5;

    logic                      S_AXI_ACLK = 1'b0;
    logic                      S_AXI_ARESET;
    logic [NUM_FW-1:0]         fw_dev_id_enable;
    logic [NUM_FW*NUM_OUT-1:0] fw_out;
    logic [NUM_FW*NUM_IN-1:0]  fw_in;
    logic [NUM_OUT-1:0]        dut_out;
    logic [NUM_IN-1:0]         dut_in;
    logic [1:0]                active_id;
    logic                      active_valid;
    logic                      switch_busy;
    logic                      sel_error;
    logic                      sel_error_clr;
    logic [CNT_W-1:0]          switch_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [NUM_OUT-1:0] out;
        logic               busy;
    } exp_t;
    exp_t sb_q[$];

    fw_dut_port_arbiter #(
        .NUM_FW(NUM_FW), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN),
        .SYNC_STAGES(2), .SWITCH_GAP(4), .OUT_IDLE('0)
    ) dut (
        .S_AXI_ACLK       (S_AXI_ACLK),
        .S_AXI_ARESET     (S_AXI_ARESET),
        .fw_dev_id_enable (fw_dev_id_enable),
        .fw_out           (fw_out),
        .fw_in            (fw_in),
        .dut_out          (dut_out),
        .dut_in           (dut_in),
        .active_id        (active_id),
        .active_valid     (active_valid),
        .switch_busy      (switch_busy),
        .sel_error        (sel_error),
        .sel_error_clr    (sel_error_clr),
        .switch_count     (switch_count)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [NUM_OUT-1:0] o, input logic b);
        exp_t e;
        e.out  = o;
        e.busy = b;
        sb_q.push_back(e);
    endtask

    // One clock edge; outputs sampled 1 ns later against the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge S_AXI_ACLK);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("dut_out", 32'(dut_out), 32'(e.out));
            check_val("switch_busy", 32'(switch_busy), 32'(e.busy));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [CNT_W-1:0] exp_cnt;
        S_AXI_ARESET     = 1'b1;
        fw_dev_id_enable = '0;
        sel_error_clr    = 1'b0;
        dut_in           = '0;
        fw_out           = {9'h133, 9'h0F0, 9'h055, 9'h1A5};
        repeat (3) tick();
        S_AXI_ARESET = 1'b0;

        // Reset state
        check_val("rst_dut_out", 32'(dut_out), 32'h0);
        check_val("rst_fw_in", 32'(fw_in), 32'h0);
        check_val("rst_active_valid", 32'(active_valid), 32'h0);
        check_val("rst_switch_count", 32'(switch_count), 32'h0);
        check_val("rst_sel_error", 32'(sel_error), 32'h0);

        // IDLE -> ACTIVE owner 0: pins follow one edge after entering ACTIVE
        fw_dev_id_enable = 4'b0001;
        push_exp(9'h000, 1'b0);
        push_exp(9'h1A5, 1'b0);
        repeat (2) tick();
        check_val("t1_active_valid", 32'(active_valid), 32'h1);
        check_val("t1_active_id", 32'(active_id), 32'h0);
        check_val("t1_switch_count", 32'(switch_count), 32'h1);

        // Owner 0 -> owner 2: four idle edges, then the new owner
        fw_dev_id_enable = 4'b0100;
        push_exp(9'h1A5, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b0);
        push_exp(9'h0F0, 1'b0);
        repeat (6) tick();
        check_val("t2_active_id", 32'(active_id), 32'h2);
        check_val("t2_switch_count", 32'(switch_count), 32'h2);

        // Multi-hot while ACTIVE: drain then IDLE, error latched
        fw_dev_id_enable = 4'b0011;
        push_exp(9'h0F0, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b0);
        push_exp(9'h000, 1'b0);
        repeat (6) tick();
        check_val("t3_idle_valid", 32'(active_valid), 32'h0);
        check_val("t3_sel_error", 32'(sel_error), 32'h1);
        check_val("t3_count_held", 32'(switch_count), 32'h2);

        // Clear together with a legal select: error clears, owner 0 granted
        fw_dev_id_enable = 4'b0001;
        sel_error_clr    = 1'b1;
        push_exp(9'h000, 1'b0);
        push_exp(9'h1A5, 1'b0);
        tick();
        sel_error_clr = 1'b0;
        check_val("t3_sel_error_clr", 32'(sel_error), 32'h0);
        check_val("t3_active_id", 32'(active_id), 32'h0);
        check_val("t3_switch_count", 32'(switch_count), 32'h3);
        tick();

        // Multi-hot with simultaneous clear: set wins; select change mid-drain keeps the gap
        fw_dev_id_enable = 4'b0011;
        sel_error_clr    = 1'b1;
        push_exp(9'h1A5, 1'b1);
        tick();
        fw_dev_id_enable = 4'b0010;
        sel_error_clr    = 1'b0;
        check_val("t3b_set_wins", 32'(sel_error), 32'h1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b1);
        push_exp(9'h000, 1'b0);
        push_exp(9'h055, 1'b0);
        repeat (5) tick();
        check_val("t3b_active_id", 32'(active_id), 32'h1);
        check_val("t3b_switch_count", 32'(switch_count), 32'h4);
        sel_error_clr = 1'b1;
        push_exp(9'h055, 1'b0);
        tick();
        sel_error_clr = 1'b0;
        check_val("t3b_sel_error_clr", 32'(sel_error), 32'h0);

        // Input path to owner 1 only, SYNC_STAGES+1 = 3 edges
        dut_in = 5'h15;
        tick();
        check_val("t4_fw_in_e1", 32'(fw_in), 32'h0);
        tick();
        check_val("t4_fw_in_e2", 32'(fw_in), 32'h0);
        tick();
        check_val("t4_fw_in_e3", 32'(fw_in), 32'(5'h15) << 5);
        dut_in = 5'h0A;
        repeat (2) tick();
        check_val("t4_fw_in_hold", 32'(fw_in), 32'(5'h15) << 5);
        tick();
        check_val("t4_fw_in_new", 32'(fw_in), 32'(5'h0A) << 5);

        // Reset asserted mid-DRAIN with a latched error
        fw_dev_id_enable = 4'b0001;
        tick();
        fw_dev_id_enable = 4'b0011;
        tick();
        check_val("t5_pre_busy", 32'(switch_busy), 32'h1);
        check_val("t5_pre_sel_error", 32'(sel_error), 32'h1);
        S_AXI_ARESET = 1'b1;
        #1;
        check_val("t5_rst_dut_out", 32'(dut_out), 32'h0);
        check_val("t5_rst_busy", 32'(switch_busy), 32'h0);
        check_val("t5_rst_active_id", 32'(active_id), 32'h0);
        check_val("t5_rst_count", 32'(switch_count), 32'h0);
        check_val("t5_rst_sel_error", 32'(sel_error), 32'h0);
        fw_dev_id_enable = 4'b0000;
        repeat (2) tick();
        S_AXI_ARESET = 1'b0;
        repeat (3) tick();
        check_val("t5_no_owner_valid", 32'(active_valid), 32'h0);
        check_val("t5_no_owner_out", 32'(dut_out), 32'h0);
        fw_dev_id_enable = 4'b0001;
        repeat (2) tick();
        check_val("t5_regrant_out", 32'(dut_out), 32'(9'h1A5));
        check_val("t5_regrant_count", 32'(switch_count), 32'h1);

        // Saturation: preload the counter near the top and keep switching
        force dut.switch_count_q = 16'hFFFC;
        #1;
        release dut.switch_count_q;
        exp_cnt = 16'hFFFC;
        for (int i = 0; i < 5; i++) begin
            fw_dev_id_enable = (i % 2 == 0) ? 4'b0010 : 4'b0001;
            repeat (5) tick();
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            check_val("t6_switch_count", 32'(switch_count), 32'(exp_cnt));
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
